midi_note_decoder: RTL and testbench
====================================

Name: midi_note_decoder

Overview:
- Parses the raw MIDI byte stream from the UART receiver and feeds the voice allocator downstream with one note event per complete Note On/Note Off message.
- Each event carries the note's playback rate (cycles_between_samples), looked up from the note number, plus a one-cycle valid pulse.
- Handles running status, velocity-0 Note On as Note Off, channel filtering, and discarding of non-note traffic.

Parameters:
- CHANNEL_FILTER_EN, 0, 1 = accept only messages on channel CHANNEL; 0 = accept all 16 channels.
- CHANNEL, 0, 4-bit MIDI channel (0..15) used when CHANNEL_FILTER_EN = 1.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- byte_in  input  8  received MIDI byte.
- byte_valid_in  input  1  one-cycle strobe: byte_in is valid this cycle.
- valid_out  output  1  one-cycle pulse: event fields are valid this cycle.
- isNoteOn  output  1  1 = Note On; 0 = Note Off.
- note_out  output  7  MIDI note number of the event.
- velocity_out  output  7  velocity; forced to 0 on Note Off.
- cycles_between_samples  output  24  playback rate for note_out.
- dropped_count  output  16  saturating count of orphan data bytes.

Behaviour:
Reset
- While rst_in = 0, all outputs are held at 0.
- The FSM returns to IDLE and the running-status register is cleared (none).
- Reset mid-message discards the partial message. No event is emitted for it.

Byte classes (evaluated only when byte_valid_in = 1)
- Realtime, F8..FF: ignored completely. FSM state, running status and any captured data byte are unchanged, including mid-message.
- System common, F0..F7: clears running status.
  - F0 enters SYSEX.
  - Any other value in this range enters IDLE.
- Channel status, 80..EF: latches the new running status and message length.
  - Length is 1 data byte for Cx and Dx, 2 for all others.
  - The FSM goes to WAIT_D1.
  - A status byte that arrives mid-message aborts the partial message.
- Data bytes, 00..7F: handled per FSM state below.

FSM states: IDLE, WAIT_D1, WAIT_D2, SYSEX
- IDLE + data byte:
  - With running status: the byte is treated as D1, and the FSM continues as if in WAIT_D1.
  - Without running status: the byte is an orphan. dropped_count increments, saturating at FFFF.
- WAIT_D1 + data byte: capture D1.
  - 1-byte message: complete, go to IDLE.
  - 2-byte message: go to WAIT_D2.
- WAIT_D2 + data byte: capture D2, message complete, go to IDLE. Running status is kept.
- SYSEX: all data bytes are ignored and not counted.
  - F7 or any non-realtime status byte exits SYSEX, with that byte handled as a normal status byte.

Event generation on message completion
- 9n with D2 ≠ 0: Note On.
- 9n with D2 = 0: Note Off.
- 8n: Note Off.
- Any other status: the message is consumed silently.
- When CHANNEL_FILTER_EN = 1 and n ≠ CHANNEL, the message is consumed silently.

Latency and outputs
- valid_out pulses high exactly 2 cycles after the byte_valid_in cycle of the completing byte.
  - Cycle 1: register note, velocity and type.
  - Cycle 2: registered LUT output.
- isNoteOn, note_out, velocity_out and cycles_between_samples are registered and hold their values until the next event.
- No backpressure exists. Back-to-back completing bytes on consecutive cycles each produce their own pulse, pipelined.

Rate arithmetic
- oct = note / 12, k = note % 12.
- cycles_between_samples = BASE_RATE[k] >> oct.
- This is an exact logical right shift, truncating. Notes 0..127 give oct 0..10.

Decomposition:
Package midi_pkg contains:
- Status-class constants and the FSM state enum.
- BASE_RATE[0..11], 24-bit each: 12000000, 11326492, 10690785, 10090757, 9524406, 8989842, 8485281, 8009039, 7559526, 7135243, 6734772, 6356779.

Sub-module midi_note_rate_lut:
- One registered cycle.
- Computes oct and k by constant division, then performs the table read and shift.

Test Plan:
- 90 3C 64 → one valid_out pulse, 2 cycles after the last byte: isNoteOn = 1, note_out = 60, velocity_out = 100, cycles_between_samples = 375000.
- 90 45 40, then running-status bytes 45 00 → Note On with rate 222976, then Note Off for note 69 with velocity_out = 0.
- 90 3C, F8, 64 → a single Note On for note 60 with velocity_out = 100; the realtime byte is transparent.
- 90 3C, then 80 3C 00 → the partial Note On is aborted; exactly one Note Off for note 60 is emitted.
- Reset, 3C 64, F0 01 02 F7, B0 07 7F → no valid_out pulses; dropped_count = 2.
- CHANNEL_FILTER_EN = 1, CHANNEL = 3: 92 3C 64 then 93 00 01 → only the second message produces an event: note 0, rate 12000000.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI note decoder: byte-class boundaries,
// parser states and the octave-0 playback-rate table.
package midi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2,
    ST_SYSEX   = 2'd3
  } midi_state_t;

  localparam logic [7:0] SYS_COMMON_FIRST = 8'hF0;
  localparam logic [7:0] REALTIME_FIRST   = 8'hF8;
  localparam logic [7:0] SYSEX_START      = 8'hF0;

  localparam logic [3:0] KIND_NOTE_OFF   = 4'h8;
  localparam logic [3:0] KIND_NOTE_ON    = 4'h9;
  localparam logic [3:0] KIND_PROGRAM    = 4'hC;
  localparam logic [3:0] KIND_CHAN_PRESS = 4'hD;

  // Rate for pitch class k in octave 0; higher octaves halve it per octave.
  function automatic logic [23:0] base_rate(input logic [3:0] k);
    case (k)
      4'd0:    base_rate = 24'd12000000;
      4'd1:    base_rate = 24'd11326492;
      4'd2:    base_rate = 24'd10690785;
      4'd3:    base_rate = 24'd10090757;
      4'd4:    base_rate = 24'd9524406;
      4'd5:    base_rate = 24'd8989842;
      4'd6:    base_rate = 24'd8485281;
      4'd7:    base_rate = 24'd8009039;
      4'd8:    base_rate = 24'd7559526;
      4'd9:    base_rate = 24'd7135243;
      4'd10:   base_rate = 24'd6734772;
      4'd11:   base_rate = 24'd6356779;
      default: base_rate = 24'd0;
    endcase
  endfunction

endpackage

// File: rtl/midi_note_rate_lut.sv
// Registered note-number to playback-rate lookup: splits the note into octave
// and pitch class, reads the base rate and shifts it down by the octave.
module midi_note_rate_lut
  import midi_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        load,
  input  logic [6:0]  note,
  output logic [23:0] rate
);

  logic [3:0] oct;
  logic [3:0] k;

  always_comb begin
    oct = 4'(note / 7'd12);
    k   = 4'(note % 7'd12);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rate <= '0;
    end else if (load) begin
      rate <= base_rate(k) >> oct;
    end
  end

endmodule

// File: rtl/midi_note_decoder.sv
// MIDI byte-stream parser producing one registered Note On/Off event per
// complete note message, two cycles after the completing byte.
// Handshake: byte_valid_in is a one-cycle strobe with no ready (the decoder
// always accepts); valid_out is a one-cycle pulse with no backpressure.
module midi_note_decoder
  import midi_pkg::*;
#(
  parameter bit         CHANNEL_FILTER_EN = 1'b0,
  parameter logic [3:0] CHANNEL           = 4'd0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid_in,
  output logic        valid_out,
  output logic        isNoteOn,
  output logic [6:0]  note_out,
  output logic [6:0]  velocity_out,
  output logic [23:0] cycles_between_samples,
  output logic [15:0] dropped_count,
  output midi_state_t state_dbg
);

  midi_state_t state, state_n;
  logic        rs_valid, rs_valid_n;
  logic [7:0]  rs_status, rs_status_n;
  logic [6:0]  d1, d1_n;
  logic        done;
  logic [6:0]  done_d1, done_d2;
  logic        drop_inc;
  logic        len1;
  logic        is_note;
  logic        ev_on;

  logic        s1_valid, s1_on;
  logic [6:0]  s1_note, s1_vel;

  assign state_dbg = state;
  assign len1 = (rs_status[7:4] == KIND_PROGRAM) || (rs_status[7:4] == KIND_CHAN_PRESS);

  always_comb begin
    state_n     = state;
    rs_valid_n  = rs_valid;
    rs_status_n = rs_status;
    d1_n        = d1;
    done        = 1'b0;
    done_d1     = d1;
    done_d2     = 7'd0;
    drop_inc    = 1'b0;
    if (byte_valid_in) begin
      if (byte_in >= REALTIME_FIRST) begin
        state_n = state;
      end else if (byte_in >= SYS_COMMON_FIRST) begin
        rs_valid_n = 1'b0;
        state_n    = (byte_in == SYSEX_START) ? ST_SYSEX : ST_IDLE;
      end else if (byte_in[7]) begin
        rs_valid_n  = 1'b1;
        rs_status_n = byte_in;
        state_n     = ST_WAIT_D1;
      end else begin
        // Under running status an idle data byte is a fresh first data byte.
        if (state == ST_WAIT_D1 || (state == ST_IDLE && rs_valid)) begin
          if (len1) begin
            done    = 1'b1;
            done_d1 = byte_in[6:0];
            state_n = ST_IDLE;
          end else begin
            d1_n    = byte_in[6:0];
            state_n = ST_WAIT_D2;
          end
        end else if (state == ST_WAIT_D2) begin
          done    = 1'b1;
          done_d2 = byte_in[6:0];
          state_n = ST_IDLE;
        end else if (state == ST_IDLE) begin
          drop_inc = 1'b1;
        end
      end
    end
  end

  always_comb begin
    is_note = done
           && (rs_status[7:4] == KIND_NOTE_ON || rs_status[7:4] == KIND_NOTE_OFF)
           && (!CHANNEL_FILTER_EN || rs_status[3:0] == CHANNEL);
    ev_on   = (rs_status[7:4] == KIND_NOTE_ON) && (done_d2 != 7'd0);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= ST_IDLE;
      rs_valid      <= 1'b0;
      rs_status     <= '0;
      d1            <= '0;
      dropped_count <= '0;
    end else begin
      state     <= state_n;
      rs_valid  <= rs_valid_n;
      rs_status <= rs_status_n;
      d1        <= d1_n;
      if (drop_inc && dropped_count != 16'hFFFF) begin
        dropped_count <= dropped_count + 16'd1;
      end
    end
  end

  // Stage 1 captures the event; stage 2 publishes it alongside the LUT result.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid     <= 1'b0;
      s1_on        <= 1'b0;
      s1_note      <= '0;
      s1_vel       <= '0;
      valid_out    <= 1'b0;
      isNoteOn     <= 1'b0;
      note_out     <= '0;
      velocity_out <= '0;
    end else begin
      s1_valid  <= is_note;
      valid_out <= s1_valid;
      if (is_note) begin
        s1_on   <= ev_on;
        s1_note <= done_d1;
        s1_vel  <= ev_on ? done_d2 : 7'd0;
      end
      if (s1_valid) begin
        isNoteOn     <= s1_on;
        note_out     <= s1_note;
        velocity_out <= s1_vel;
      end
    end
  end

  midi_note_rate_lut u_rate_lut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .load   (s1_valid),
    .note   (s1_note),
    .rate   (cycles_between_samples)
  );

endmodule

// File: tb/tb_midi_note_decoder.sv
// Scoreboard bench for midi_note_decoder: one unfiltered instance and one
// filtered to channel 3 share the byte stream; a monitor checks every event.
module tb_midi_note_decoder;
  import midi_pkg::*;

  logic        clk_in;
  logic        rst_in;
  logic [7:0]  byte_in;
  logic        byte_valid_in;

  logic        va, on_a, vb, on_b;
  logic [6:0]  note_a, vel_a, note_b, vel_b;
  logic [23:0] rate_a, rate_b;
  logic [15:0] drop_a, drop_b;
  midi_state_t st_a, st_b;

  logic [38:0] exp_qa[$];
  logic [38:0] exp_qb[$];
  int          cyc_qa[$];
  int          cyc_qb[$];
  int          cyc;
  int          checks;
  int          failures;

  midi_note_decoder dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .byte_in(byte_in), .byte_valid_in(byte_valid_in),
    .valid_out(va), .isNoteOn(on_a), .note_out(note_a), .velocity_out(vel_a),
    .cycles_between_samples(rate_a), .dropped_count(drop_a), .state_dbg(st_a)
  );

  midi_note_decoder #(.CHANNEL_FILTER_EN(1'b1), .CHANNEL(4'd3)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .byte_in(byte_in), .byte_valid_in(byte_valid_in),
    .valid_out(vb), .isNoteOn(on_b), .note_out(note_b), .velocity_out(vel_b),
    .cycles_between_samples(rate_b), .dropped_count(drop_b), .state_dbg(st_b)
  );

  // Clock and reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [38:0] ev(input bit on, input int note, input int vel, input int rate);
    logic [6:0]  n7;
    logic [6:0]  v7;
    logic [23:0] r24;
    n7  = note[6:0];
    v7  = vel[6:0];
    r24 = rate[23:0];
    return {on, n7, v7, r24};
  endfunction

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      byte_valid_in = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk_in);
    byte_in       = b;
    byte_valid_in = 1'b1;
  endtask

  task automatic send_done(input logic [7:0] b, input logic [38:0] e, input bit to_a, input bit to_b);
    @(negedge clk_in);
    byte_in       = b;
    byte_valid_in = 1'b1;
    if (to_a) begin exp_qa.push_back(e); cyc_qa.push_back(cyc + 2); end
    if (to_b) begin exp_qb.push_back(e); cyc_qb.push_back(cyc + 2); end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    byte_valid_in = 1'b0;
    rst_in        = 1'b0;
    idle(2);
  endtask

  task automatic release_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  // Scoreboard monitor
  task automatic check_event(input int which, input logic [38:0] got);
    logic [38:0] e;
    int          c;
    checks++;
    if ((which == 0 && exp_qa.size() == 0) || (which == 1 && exp_qb.size() == 0)) begin
      failures++;
      $display("FAIL unexpected_event dut=%0d got=%h expected=none cycle=%0d", which, got, cyc);
      return;
    end
    if (which == 0) begin e = exp_qa.pop_front(); c = cyc_qa.pop_front(); end
    else            begin e = exp_qb.pop_front(); c = cyc_qb.pop_front(); end
    if (got !== e) begin
      failures++;
      $display("FAIL event dut=%0d got on=%0d note=%0d vel=%0d rate=%0d expected on=%0d note=%0d vel=%0d rate=%0d",
               which, got[38], got[37:31], got[30:24], got[23:0], e[38], e[37:31], e[30:24], e[23:0]);
    end
    checks++;
    if (c != cyc) begin
      failures++;
      $display("FAIL event_latency dut=%0d got_cycle=%0d expected_cycle=%0d", which, cyc, c);
    end
  endtask

  always @(posedge clk_in) begin
    #1;
    if (va === 1'b1) check_event(0, {on_a, note_a, vel_a, rate_a});
    if (vb === 1'b1) check_event(1, {on_b, note_b, vel_b, rate_b});
  end

  initial begin
    checks        = 0;
    failures      = 0;
    byte_in       = 8'h00;
    byte_valid_in = 1'b0;
    rst_in        = 1'b0;
    idle(3);
    check_val("reset_valid", {31'd0, va}, 32'd0);
    check_val("reset_note", {25'd0, note_a}, 32'd0);
    check_val("reset_rate", {8'd0, rate_a}, 32'd0);
    check_val("reset_dropped", {16'd0, drop_a}, 32'd0);
    check_val("reset_state", {30'd0, st_a}, {30'd0, ST_IDLE});
    release_reset();

    // Basic Note On
    send(8'h90); send(8'h3C);
    send_done(8'h64, ev(1, 60, 100, 375000), 1, 0);
    idle(4);

    // Running status with velocity-0 Note On as Note Off
    send(8'h90); send(8'h45);
    send_done(8'h40, ev(1, 69, 64, 222976), 1, 0);
    send(8'h45);
    send_done(8'h00, ev(0, 69, 0, 222976), 1, 0);
    idle(4);
    check_val("held_note", {25'd0, note_a}, 32'd69);

    // Realtime byte mid-message is transparent
    send(8'h90); send(8'h3C); send(8'hF8);
    send_done(8'h64, ev(1, 60, 100, 375000), 1, 0);
    idle(4);

    // Status byte aborts a partial message
    send(8'h90); send(8'h3C);
    send(8'h80); send(8'h3C);
    send_done(8'h00, ev(0, 60, 0, 375000), 1, 0);
    idle(4);

    // Reset mid-message, orphans, sysex, non-note traffic
    send(8'h90); send(8'h3C);
    do_reset();
    check_val("in_reset_note", {25'd0, note_a}, 32'd0);
    check_val("in_reset_on", {31'd0, on_a}, 32'd0);
    release_reset();
    send(8'h3C); send(8'h64);
    send(8'hF0);
    idle(1);
    check_val("sysex_state", {30'd0, st_a}, {30'd0, ST_SYSEX});
    send(8'h01); send(8'h02); send(8'hF7);
    send(8'hB0); send(8'h07); send(8'h7F);
    idle(4);
    check_val("dropped_a", {16'd0, drop_a}, 32'd2);
    check_val("dropped_b", {16'd0, drop_b}, 32'd2);

    // Channel status byte exits sysex directly
    send(8'hF0); send(8'h01); send(8'h90); send(8'h3C);
    send_done(8'h64, ev(1, 60, 100, 375000), 1, 0);
    idle(4);

    // Note Off forces velocity to 0; highest note and octave 10
    send(8'h80); send(8'h7F);
    send_done(8'h55, ev(0, 127, 0, 7821), 1, 0);
    idle(1);
    // Lowest note, then a pitch class in octave 5
    send(8'h90); send(8'h00);
    send_done(8'h7F, ev(1, 0, 127, 12000000), 1, 0);
    send(8'h3E);
    send_done(8'h01, ev(1, 62, 1, 334087), 1, 0);
    idle(4);

    // Channel filter: channel 2 passes only unfiltered, channel 3 passes both
    send(8'h92); send(8'h3C);
    send_done(8'h64, ev(1, 60, 100, 375000), 1, 0);
    send(8'h93); send(8'h00);
    send_done(8'h01, ev(1, 0, 1, 12000000), 1, 1);
    idle(6);

    check_val("dropped_a_final", {16'd0, drop_a}, 32'd2);
    check_val("pending_a", exp_qa.size(), 32'd0);
    check_val("pending_b", exp_qb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
